// File: rtl/xor_cksum_pkg.sv
// rtl/xor_cksum_pkg.sv - shared state and mode encodings for the xor_cksum engine
package xor_cksum_pkg;

    typedef enum logic [1:0] {
        XC_IDLE  = 2'd0,
        XC_ACCUM = 2'd1,
        XC_DONE  = 2'd2
    } xc_state_e;

    localparam logic XC_MODE_XOR = 1'b0;
    localparam logic XC_MODE_CRC = 1'b1;

endpackage

// File: rtl/xor_cksum_if.sv
// rtl/xor_cksum_if.sv - data-beat and checksum-result handshake bundle for xor_cksum
interface xor_cksum_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             mode;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_parity;

    modport master (
        output in_valid, in_data, in_last, mode, abort, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_parity
    );

    modport slave (
        input  in_valid, in_data, in_last, mode, abort, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_parity
    );
endinterface

// File: rtl/xor_cksum_fold.sv
// rtl/xor_cksum_fold.sv - combinational single-word fold: plain XOR or unrolled MSB-first CRC
module xor_cksum_fold
    import xor_cksum_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] CRC_POLY = 16'h1021
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] data,
    input  logic             mode,
    output logic [WIDTH-1:0] res
);
    logic [WIDTH-1:0] c;

    // One shift-and-conditional-xor step per bit of the word, non-reflected, no final xor.
    always_comb begin
        c = acc ^ data;
        if (mode == XC_MODE_CRC) begin
            for (int i = 0; i < WIDTH; i++) begin
                c = c[WIDTH-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
            end
        end
        res = c;
    end
endmodule

// File: rtl/xor_cksum.sv
// rtl/xor_cksum.sv - streaming XOR/CRC checksum engine; XOR_CKSUM_PARITY_EN enables out_parity
module xor_cksum
    import xor_cksum_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] CRC_POLY = 16'h1021,
    parameter logic [WIDTH-1:0] INIT     = '0,
    parameter int               CNT_W    = 8
) (
    input logic        clk,
    input logic        rst_n,
    xor_cksum_if.slave bus
);
    xc_state_e        state, state_next;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count, count_next;
    logic             mode_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             in_ready;
    logic             beat;
    logic [WIDTH-1:0] fold_acc, fold_res;
    logic             fold_mode;

    assign beat       = bus.in_valid && in_ready;
    // The first beat folds against INIT with the live mode pin; later beats use the latched mode.
    assign fold_acc   = (state == XC_IDLE) ? INIT : acc;
    assign fold_mode  = (state == XC_IDLE) ? bus.mode : mode_q;
    assign count_next = (state == XC_IDLE) ? CNT_W'(1)
                      : ((&count) ? count : count + CNT_W'(1));

    xor_cksum_fold #(
        .WIDTH    (WIDTH),
        .CRC_POLY (CRC_POLY)
    ) u_fold (
        .acc  (fold_acc),
        .data (bus.in_data),
        .mode (fold_mode),
        .res  (fold_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= XC_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            XC_IDLE, XC_ACCUM: begin
                if (bus.abort)  state_next = XC_IDLE;
                else if (beat)  state_next = bus.in_last ? XC_DONE : XC_ACCUM;
            end
            XC_DONE:  if (bus.out_ready) state_next = XC_IDLE;
            default:  state_next = XC_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state != XC_DONE) && !bus.abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= INIT;
            count       <= '0;
            mode_q      <= XC_MODE_XOR;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
        end else if (state == XC_DONE) begin
            // Abort has no effect here; only the result handshake leaves DONE.
            if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                acc         <= INIT;
                count       <= '0;
            end
        end else if (bus.abort) begin
            acc   <= INIT;
            count <= '0;
        end else if (beat) begin
            acc   <= fold_res;
            count <= count_next;
            if (state == XC_IDLE) mode_q <= bus.mode;
            if (bus.in_last) begin
                out_valid_q <= 1'b1;
                out_sum_q   <= fold_res;
                out_count_q <= count_next;
            end
        end
    end

`ifdef XOR_CKSUM_PARITY_EN
    logic out_parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       out_parity_q <= 1'b0;
        else if (state != XC_DONE && !bus.abort && beat && bus.in_last) out_parity_q <= ^fold_res;
    end

    assign bus.out_parity = out_parity_q;
`else
    assign bus.out_parity = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_xor_cksum.sv
// tb/tb_xor_cksum.sv - randomized self-checking bench for xor_cksum against a polynomial-division model
module tb_xor_cksum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    xor_cksum_if #(.WIDTH(16), .CNT_W(8)) bus ();
    xor_cksum_if #(.WIDTH(16), .CNT_W(2)) bus2 ();

    xor_cksum #(.WIDTH(16), .CRC_POLY(16'h1021), .INIT(16'h0000), .CNT_W(8)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (bus.slave)
    );
    xor_cksum #(.WIDTH(16), .CRC_POLY(16'h1021), .INIT(16'h0000), .CNT_W(2)) u_sat (
        .clk (clk), .rst_n (rst_n), .bus (bus2.slave)
    );

    always #5 clk = ~clk;

    logic [15:0] tx_words[$];
    logic        tx_modes[$];

    // CRC as remainder of (acc^d)*x^16 modulo the generator x^16 + poly.
    function automatic logic [15:0] ref_fold(logic [15:0] a, logic [15:0] d, logic m);
        logic [31:0] r;
        logic [31:0] g;
        if (!m) return a ^ d;
        r = {a ^ d, 16'h0000};
        g = 32'h0001_1021;
        for (int b = 31; b >= 16; b--) if (r[b]) r = r ^ (g << (b - 16));
        return r[15:0];
    endfunction

    function automatic logic [15:0] ref_frame();
        logic [15:0] s = 16'h0000;
        foreach (tx_words[i]) s = ref_fold(s, tx_words[i], tx_modes[0]);
        return s;
    endfunction

    function automatic int ref_count(int n, int cnt_w);
        int lim = (1 << cnt_w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    function automatic logic ref_parity(logic [15:0] s);
`ifdef XOR_CKSUM_PARITY_EN
        return ^s;
`else
        return 1'b0;
`endif
    endfunction

    task automatic send_frame(input bit sat, input int gap_max, input bit no_last);
        for (int i = 0; i < tx_words.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            @(negedge clk);
            if (sat) begin
                bus2.in_valid = 1'b1; bus2.in_data = tx_words[i]; bus2.mode = tx_modes[i];
                bus2.in_last = !no_last && (i == tx_words.size() - 1);
            end else begin
                bus.in_valid = 1'b1; bus.in_data = tx_words[i]; bus.mode = tx_modes[i];
                bus.in_last = !no_last && (i == tx_words.size() - 1);
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0; bus.in_last = 1'b0;
            bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
        end
    endtask

    task automatic handshake(input bit sat);
        @(negedge clk);
        if (sat) bus2.out_ready = 1'b1; else bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0; bus2.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'h0) begin errors++; $display("FAIL reset_out_sum got %h want 0000", bus.out_sum); end
        checks++; if (bus.out_count !== 8'h0) begin errors++; $display("FAIL reset_out_count got %0d want 0", bus.out_count); end
        checks++; if (bus.out_parity !== 1'b0) begin errors++; $display("FAIL reset_out_parity got %b want 0", bus.out_parity); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_xor_directed();
        tx_words = '{16'h1234, 16'h00FF, 16'hF0F0};
        tx_modes = '{1'b0, 1'b0, 1'b0};
        bus.out_ready = 1'b1;
        send_frame(1'b0, 0, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL xor_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'hE23B) begin errors++; $display("FAIL xor_sum got %h want e23b", bus.out_sum); end
        checks++; if (bus.out_count !== 8'd3) begin errors++; $display("FAIL xor_count got %0d want 3", bus.out_count); end
        checks++; if (bus.out_parity !== ref_parity(16'hE23B)) begin errors++; $display("FAIL xor_parity got %b want %b", bus.out_parity, ref_parity(16'hE23B)); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL xor_valid_drop got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL xor_ready_back got %b want 1", bus.in_ready); end
    endtask

    task automatic test_crc_single();
        tx_words = '{16'h8000};
        tx_modes = '{1'b1};
        send_frame(1'b0, 0, 1'b0);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL crc1_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'h1B98) begin errors++; $display("FAIL crc1_sum got %h want 1b98", bus.out_sum); end
        checks++; if (bus.out_count !== 8'd1) begin errors++; $display("FAIL crc1_count got %0d want 1", bus.out_count); end
        checks++; if (bus.out_parity !== ref_parity(16'h1B98)) begin errors++; $display("FAIL crc1_parity got %b want %b", bus.out_parity, ref_parity(16'h1B98)); end
        handshake(1'b0);
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_sum;
        tx_words = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        tx_modes = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_sum = ref_frame();
        send_frame(1'b0, 1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_data = 16'($urandom); bus.in_last = 1'($urandom);
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_sum) begin errors++; $display("FAIL bp_hold cycle %0d got v=%b %h want v=1 %h", c, bus.out_valid, bus.out_sum, exp_sum); end
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
        tx_words = '{16'h0F0F};
        tx_modes = '{1'b0};
        send_frame(1'b0, 0, 1'b0);
        @(negedge clk);
        checks++; if (bus.out_sum !== 16'h0F0F || bus.out_count !== 8'd1) begin errors++; $display("FAIL bp_no_stray_beat got %h/%0d want 0f0f/1", bus.out_sum, bus.out_count); end
        handshake(1'b0);
    endtask

    task automatic test_abort();
        tx_words = '{16'hAAAA, 16'h5555};
        tx_modes = '{1'b0, 1'b0};
        send_frame(1'b0, 0, 1'b1);
        @(negedge clk);
        bus.abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h1111; bus.in_last = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got %b want 0", bus.in_ready); end
        @(posedge clk);
        #1 bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_valid got %b want 0", bus.out_valid); end
        tx_words = '{16'h0001};
        tx_modes = '{1'b0};
        send_frame(1'b0, 0, 1'b0);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h0001) begin errors++; $display("FAIL abort_next_sum got v=%b %h want v=1 0001", bus.out_valid, bus.out_sum); end
        checks++; if (bus.out_count !== 8'd1) begin errors++; $display("FAIL abort_next_count got %0d want 1", bus.out_count); end
        handshake(1'b0);
    endtask

    task automatic test_mode_latch();
        logic [15:0] exp_sum;
        for (int f = 0; f < 2; f++) begin
            int len = $urandom_range(3, 6);
            tx_words.delete(); tx_modes.delete();
            for (int i = 0; i < len; i++) begin
                tx_words.push_back(16'($urandom));
                tx_modes.push_back((i == 0) ? (f == 0) : (f != 0));
            end
            exp_sum = ref_frame();
            send_frame(1'b0, 1, 1'b0);
            @(negedge clk);
            checks++; if (bus.out_sum !== exp_sum) begin errors++; $display("FAIL mode_latch_sum frame %0d got %h want %h", f, bus.out_sum, exp_sum); end
            checks++; if (bus.out_count !== 8'(len)) begin errors++; $display("FAIL mode_latch_count frame %0d got %0d want %0d", f, bus.out_count, len); end
            handshake(1'b0);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_sum;
        for (int f = 0; f < 20; f++) begin
            int  len = $urandom_range(1, 8);
            bit  m   = 1'($urandom);
            tx_words.delete(); tx_modes.delete();
            for (int i = 0; i < len; i++) begin
                tx_words.push_back(16'($urandom));
                tx_modes.push_back((i == 0) ? m : 1'($urandom));
            end
            exp_sum = ref_frame();
            send_frame(1'b0, 2, 1'b0);
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rand_valid frame %0d got %b want 1", f, bus.out_valid); end
            checks++; if (bus.out_sum !== exp_sum) begin errors++; $display("FAIL rand_sum frame %0d got %h want %h", f, bus.out_sum, exp_sum); end
            checks++; if (bus.out_count !== 8'(len)) begin errors++; $display("FAIL rand_count frame %0d got %0d want %0d", f, bus.out_count, len); end
            checks++; if (bus.out_parity !== ref_parity(exp_sum)) begin errors++; $display("FAIL rand_parity frame %0d got %b want %b", f, bus.out_parity, ref_parity(exp_sum)); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake(1'b0);
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rand_drop frame %0d got %b want 0", f, bus.out_valid); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_sum;
        for (int f = 0; f < 2; f++) begin
            int len = (f == 0) ? 5 : 3;
            tx_words.delete(); tx_modes.delete();
            for (int i = 0; i < len; i++) begin
                tx_words.push_back(16'($urandom));
                tx_modes.push_back(f == 0);
            end
            exp_sum = ref_frame();
            send_frame(1'b1, 1, 1'b0);
            @(negedge clk);
            checks++; if (bus2.out_count !== 2'(ref_count(len, 2))) begin errors++; $display("FAIL sat_count len %0d got %0d want %0d", len, bus2.out_count, ref_count(len, 2)); end
            checks++; if (bus2.out_sum !== exp_sum) begin errors++; $display("FAIL sat_sum len %0d got %h want %h", len, bus2.out_sum, exp_sum); end
            handshake(1'b1);
        end
    endtask

    task automatic test_async_reset();
        tx_words = '{16'h1357, 16'h2468};
        tx_modes = '{1'b0, 1'b0};
        send_frame(1'b0, 0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_sum !== 16'h0 || bus.out_count !== 8'h0 || bus.out_parity !== 1'b0) begin
            errors++; $display("FAIL areset_done_outputs got v=%b %h %0d p=%b want all 0", bus.out_valid, bus.out_sum, bus.out_count, bus.out_parity);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got %b want 1", bus.in_ready); end
        tx_words = '{16'h4444, 16'h8888, 16'h1111};
        tx_modes = '{1'b1, 1'b1, 1'b1};
        send_frame(1'b0, 0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL areset_mid got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready); end
        @(negedge clk) rst_n = 1'b1;
        tx_words = '{16'hBEEF};
        tx_modes = '{1'b0};
        send_frame(1'b0, 0, 1'b0);
        @(negedge clk);
        checks++; if (bus.out_sum !== 16'hBEEF || bus.out_count !== 8'd1) begin errors++; $display("FAIL areset_fresh_frame got %h/%0d want beef/1", bus.out_sum, bus.out_count); end
        handshake(1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.mode = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0; bus2.mode = 1'b0; bus2.abort = 1'b0; bus2.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_xor_directed();
        test_crc_single();
        test_backpressure();
        test_abort();
        test_mode_latch();
        test_random();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
